// File: rtl/pong_pkg.sv
// Shared state encoding and default screen geometry for the pong engine and renderer.
package pong_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StServeWait = 2'd1,
    StPlay      = 2'd2,
    StScored    = 2'd3
  } pong_state_e;

  localparam int unsigned DefHRes         = 640;
  localparam int unsigned DefVRes         = 480;
  localparam int unsigned DefTWallB       = 71;
  localparam int unsigned DefBWallT       = 472;
  localparam int unsigned DefLPadX        = 36;
  localparam int unsigned DefRPadX        = 600;
  localparam int unsigned DefPadW         = 4;
  localparam int unsigned DefPadH         = 72;
  localparam int unsigned DefPadVel       = 3;
  localparam int unsigned DefBallSize     = 8;
  localparam int unsigned DefVelMin       = 1;
  localparam int unsigned DefVelMax       = 4;
  localparam int unsigned DefHitsPerLevel = 4;
  localparam int unsigned DefServeFrames  = 60;

endpackage

// File: rtl/pong_if.sv
// Control inputs and position/event outputs between frame timing, engine and renderer.
interface pong_if;

  logic       frame_tick;
  logic [3:0] btn;
  logic       serve;
  logic       pause;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] l_pad_y;
  logic [9:0] r_pad_y;
  logic [1:0] hit;
  logic [1:0] miss;
  logic [2:0] speed;
  logic [1:0] state;

  modport master (
    output frame_tick, btn, serve, pause,
    input  ball_x, ball_y, l_pad_y, r_pad_y, hit, miss, speed, state
  );

  modport slave (
    input  frame_tick, btn, serve, pause,
    output ball_x, ball_y, l_pad_y, r_pad_y, hit, miss, speed, state
  );

endinterface

// File: rtl/pong_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4; maximal length so it never reaches zero.
module pong_lfsr8 (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= 8'h5A;
    else       q_q <= {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  assign q = q_q;

endmodule

// File: rtl/pong_physics_engine.sv
// Ball/paddle state, serve countdown and collision resolution, advanced once per frame tick.
module pong_physics_engine
  import pong_pkg::*;
#(
  parameter int unsigned H_RES          = DefHRes,
  parameter int unsigned V_RES          = DefVRes,
  parameter int unsigned T_WALL_B       = DefTWallB,
  parameter int unsigned B_WALL_T       = DefBWallT,
  parameter int unsigned L_PAD_X        = DefLPadX,
  parameter int unsigned R_PAD_X        = DefRPadX,
  parameter int unsigned PAD_W          = DefPadW,
  parameter int unsigned PAD_H          = DefPadH,
  parameter int unsigned PAD_VEL        = DefPadVel,
  parameter int unsigned BALL_SIZE      = DefBallSize,
  parameter int unsigned VEL_MIN        = DefVelMin,
  parameter int unsigned VEL_MAX        = DefVelMax,
  parameter int unsigned HITS_PER_LEVEL = DefHitsPerLevel,
  parameter int unsigned SERVE_FRAMES   = DefServeFrames
) (
  input  logic   clk,
  input  logic   reset,
  pong_if.slave  bus
);

  localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);
  localparam int unsigned HitW = $clog2(HITS_PER_LEVEL + 1);

  localparam logic [9:0]  BallX0 = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  BallY0 = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  PadY0  = 10'((V_RES - PAD_H) / 2);
  localparam logic [10:0] WallT  = 11'(T_WALL_B);
  localparam logic [10:0] WallB  = 11'(B_WALL_T);
  localparam logic [10:0] Bs1    = 11'(BALL_SIZE - 1);
  localparam logic [10:0] PadH1  = 11'(PAD_H - 1);
  localparam logic [10:0] LPadL  = 11'(L_PAD_X);
  localparam logic [10:0] LPadR  = 11'(L_PAD_X + PAD_W - 1);
  localparam logic [10:0] RPadL  = 11'(R_PAD_X);
  localparam logic [10:0] RPadR  = 11'(R_PAD_X + PAD_W - 1);
  localparam logic [10:0] MaxX   = 11'(H_RES - BALL_SIZE);

  pong_state_e     state_q, state_d;
  logic [9:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [9:0]      l_pad_q, l_pad_d, r_pad_q, r_pad_d;
  logic            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0]      speed_q, speed_d;
  logic [HitW-1:0] hits_q, hits_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      hit_q, hit_d, miss_q, miss_d;

  logic [7:0]  lfsr;
  logic        unused_lfsr;
  logic        tick, under;
  logic [10:0] nx, ny, spd;

  pong_lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:2];

  // Down wins when both buttons are held; a blocked step is simply not taken.
  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic dn, input logic up);
    logic [10:0] yw;
    yw       = {1'b0, y};
    pad_step = y;
    if (dn) begin
      if (yw + 11'(PAD_H - 1 + PAD_VEL) < WallB) pad_step = y + 10'(PAD_VEL);
    end else if (up) begin
      if (yw > 11'(T_WALL_B + PAD_VEL)) pad_step = y - 10'(PAD_VEL);
    end
  endfunction

  function automatic logic overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                   input logic [10:0] b_lo, input logic [10:0] b_hi);
    overlap = (a_lo <= b_hi) && (a_hi >= b_lo);
  endfunction

  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    l_pad_d  = l_pad_q;
    r_pad_d  = r_pad_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    speed_d  = speed_q;
    hits_d   = hits_q;
    cnt_d    = cnt_q;
    hit_d    = 2'b00;
    miss_d   = 2'b00;
    tick     = bus.frame_tick & ~bus.pause;
    spd      = 11'(speed_q);
    under    = ~dir_x_q && ({1'b0, ball_x_q} < spd);
    nx       = dir_x_q ? {1'b0, ball_x_q} + spd : (under ? 11'd0 : {1'b0, ball_x_q} - spd);
    ny       = dir_y_q ? {1'b0, ball_y_q} + spd : {1'b0, ball_y_q} - spd;

    if (tick) begin
      l_pad_d = pad_step(l_pad_q, bus.btn[3], bus.btn[2]);
      r_pad_d = pad_step(r_pad_q, bus.btn[1], bus.btn[0]);
    end

    case (state_q)
      StIdle, StScored: begin
        if (bus.serve) begin
          state_d = StServeWait;
          dir_x_d = lfsr[0];
          dir_y_d = lfsr[1];
          cnt_d   = CntW'(SERVE_FRAMES);
        end
      end
      StServeWait: begin
        if (tick) begin
          if (cnt_q <= CntW'(1)) begin
            cnt_d   = '0;
            state_d = StPlay;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      StPlay: begin
        if (miss_q != 2'b00) begin
          state_d  = StScored;
          ball_x_d = BallX0;
          ball_y_d = BallY0;
          speed_d  = 3'(VEL_MIN);
          hits_d   = '0;
        end else if (tick) begin
          if (ny <= WallT) begin
            dir_y_d = 1'b1;
            ny      = WallT + 11'd1;
          end else if (ny + Bs1 >= WallB) begin
            dir_y_d = 1'b0;
            ny      = WallB - 11'(BALL_SIZE);
          end
          // Paddle tests use this frame's paddle positions and the wall-clamped ball row.
          if (!dir_x_q && overlap(nx, nx + Bs1, LPadL, LPadR) &&
              overlap(ny, ny + Bs1, {1'b0, l_pad_d}, {1'b0, l_pad_d} + PadH1)) begin
            dir_x_d = 1'b1;
            nx      = LPadR + 11'd1;
            hit_d   = 2'b01;
          end else if (dir_x_q && overlap(nx, nx + Bs1, RPadL, RPadR) &&
                       overlap(ny, ny + Bs1, {1'b0, r_pad_d}, {1'b0, r_pad_d} + PadH1)) begin
            dir_x_d = 1'b0;
            nx      = RPadL - 11'(BALL_SIZE);
            hit_d   = 2'b10;
          end else if (dir_x_q && nx > MaxX) begin
            miss_d = 2'b01;
          end else if (under) begin
            miss_d = 2'b10;
          end
          ball_x_d = nx[9:0];
          ball_y_d = ny[9:0];
          if (hit_d != 2'b00) begin
            if (hits_q == HitW'(HITS_PER_LEVEL - 1)) begin
              hits_d = '0;
              if (speed_q < 3'(VEL_MAX)) speed_d = speed_q + 3'd1;
            end else begin
              hits_d = hits_q + HitW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ball_x_q <= BallX0;
      ball_y_q <= BallY0;
      l_pad_q  <= PadY0;
      r_pad_q  <= PadY0;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      speed_q  <= 3'(VEL_MIN);
      hits_q   <= '0;
      cnt_q    <= '0;
      hit_q    <= 2'b00;
      miss_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      l_pad_q  <= l_pad_d;
      r_pad_q  <= r_pad_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      speed_q  <= speed_d;
      hits_q   <= hits_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.ball_x  = ball_x_q;
  assign bus.ball_y  = ball_y_q;
  assign bus.l_pad_y = l_pad_q;
  assign bus.r_pad_y = r_pad_q;
  assign bus.hit     = hit_q;
  assign bus.miss    = miss_q;
  assign bus.speed   = speed_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_pong_physics_engine.sv
// Scoreboard bench: a frame-level reference model queues expected outputs, a monitor checks them.
module tb_pong_physics_engine;
  import pong_pkg::*;

  localparam int TW = DefTWallB, BW = DefBWallT, PH = DefPadH, PV = DefPadVel;
  localparam int BS = DefBallSize, LX = DefLPadX, RX = DefRPadX, PW = DefPadW;
  localparam int CX = (DefHRes - DefBallSize) / 2, CY = (DefVRes - DefBallSize) / 2;
  localparam int PY0 = (DefVRes - DefPadH) / 2;

  typedef struct packed {
    int bx; int by; int lp; int rp; int hit; int miss; int spd; int st; int post_st;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  pong_if bus ();

  pong_physics_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t q_exp[$];
  exp_t mon_e;
  int   mon_post;
  int   n_total = 0, n_pass = 0, n_hits = 0, n_miss = 0;
  logic t1, t2;

  // Reference model state
  int m_bx, m_by, m_lp, m_rp, m_vx_pos, m_vy_pos, m_spd, m_hits, m_cnt, m_st;
  logic [7:0] m_lfsr;

  task automatic check(input string name, input bit ok, input string detail);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic model_reset();
    m_bx = CX; m_by = CY; m_lp = PY0; m_rp = PY0;
    m_vx_pos = 0; m_vy_pos = 0; m_spd = DefVelMin; m_hits = 0; m_cnt = 0; m_st = 0;
    m_lfsr = 8'h5A;
  endtask

  // Advance one clock; the LFSR model follows the DUT register cycle by cycle.
  task automatic step();
    @(posedge clk);
    if (!reset) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    @(negedge clk);
  endtask

  function automatic int pad_move(input int y, input bit dn, input bit up);
    if (dn) return (y + PH - 1 + PV < BW) ? y + PV : y;
    if (up) return (y - PV > TW) ? y - PV : y;
    return y;
  endfunction

  // Intervals [a, a+la) and [b, b+lb) share a pixel.
  function automatic bit spans_meet(input int a, input int la, input int b, input int lb);
    return (a < b + lb) && (b < a + la);
  endfunction

  task automatic model_serve();
    if (m_st == 0 || m_st == 3) begin
      m_vx_pos = m_lfsr[0]; m_vy_pos = m_lfsr[1]; m_cnt = DefServeFrames; m_st = 1;
    end
  endtask

  task automatic model_frame(input logic [3:0] b, input bit p, output exp_t e);
    int hit = 0, miss = 0, vx, vy, nx, ny;
    bit gone_left;
    if (!p) begin
      m_lp = pad_move(m_lp, b[3], b[2]);
      m_rp = pad_move(m_rp, b[1], b[0]);
      if (m_st == 1) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_st = 2;
      end else if (m_st == 2) begin
        vx = m_vx_pos ? m_spd : -m_spd;
        vy = m_vy_pos ? m_spd : -m_spd;
        nx = m_bx + vx;
        ny = m_by + vy;
        gone_left = (nx < 0);
        if (gone_left) nx = 0;
        if (ny <= TW) begin
          ny = TW + 1; m_vy_pos = 1;
        end else if (ny + BS > BW) begin
          ny = BW - BS; m_vy_pos = 0;
        end
        if (vx < 0 && spans_meet(nx, BS, LX, PW) && spans_meet(ny, BS, m_lp, PH)) begin
          nx = LX + PW; m_vx_pos = 1; hit = 1;
        end else if (vx > 0 && spans_meet(nx, BS, RX, PW) && spans_meet(ny, BS, m_rp, PH)) begin
          nx = RX - BS; m_vx_pos = 0; hit = 2;
        end else if (vx > 0 && nx > DefHRes - BS) begin
          miss = 1;
        end else if (gone_left) begin
          miss = 2;
        end
        m_bx = nx; m_by = ny;
        if (hit != 0) begin
          n_hits++;
          m_hits++;
          if (m_hits == DefHitsPerLevel) begin
            m_hits = 0;
            m_spd  = (m_spd + 1 > DefVelMax) ? DefVelMax : m_spd + 1;
          end
        end
      end
    end
    e = '{bx: m_bx, by: m_by, lp: m_lp, rp: m_rp, hit: hit, miss: miss, spd: m_spd, st: m_st,
          post_st: 0};
    if (miss != 0) begin
      n_miss++;
      m_st = 3; m_bx = CX; m_by = CY; m_spd = DefVelMin; m_hits = 0;
    end
    e.post_st = m_st;
  endtask

  // Four cycles per frame: tick, response, scored settles, optional serve.
  task automatic frame(input logic [3:0] b, input bit p, input bit do_serve);
    exp_t e;
    bus.btn = b; bus.pause = p; bus.frame_tick = 1'b1;
    model_frame(b, p, e);
    q_exp.push_back(e);
    step();
    bus.frame_tick = 1'b0;
    step();
    if (do_serve) begin
      bus.serve = 1'b1;
      model_serve();
    end
    step();
    bus.serve = 1'b0;
    step();
  endtask

  task automatic check_reset_vals(input string name);
    check(name, bus.ball_x == 10'(CX) && bus.ball_y == 10'(CY) && bus.l_pad_y == 10'(PY0) &&
          bus.r_pad_y == 10'(PY0) && bus.hit == 2'b00 && bus.miss == 2'b00 &&
          bus.speed == 3'(DefVelMin) && bus.state == 2'd0,
          $sformatf("got ball=(%0d,%0d) pads=%0d/%0d hit=%0d miss=%0d spd=%0d st=%0d",
                    bus.ball_x, bus.ball_y, bus.l_pad_y, bus.r_pad_y, bus.hit, bus.miss,
                    bus.speed, bus.state));
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t1 <= 1'b0;
      t2 <= 1'b0;
    end else begin
      t1 <= bus.frame_tick;
      t2 <= t1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (t1) begin
        if (q_exp.size() == 0) begin
          check("scoreboard_underflow", 1'b0, "response seen with empty queue");
        end else begin
          mon_e    = q_exp.pop_front();
          mon_post = mon_e.post_st;
          check("frame", int'(bus.ball_x) == mon_e.bx && int'(bus.ball_y) == mon_e.by &&
                int'(bus.l_pad_y) == mon_e.lp && int'(bus.r_pad_y) == mon_e.rp &&
                int'(bus.hit) == mon_e.hit && int'(bus.miss) == mon_e.miss &&
                int'(bus.speed) == mon_e.spd && int'(bus.state) == mon_e.st,
                $sformatf("got (%0d,%0d) l%0d r%0d h%0d m%0d s%0d st%0d want (%0d,%0d) l%0d r%0d h%0d m%0d s%0d st%0d",
                          bus.ball_x, bus.ball_y, bus.l_pad_y, bus.r_pad_y, bus.hit, bus.miss,
                          bus.speed, bus.state, mon_e.bx, mon_e.by, mon_e.lp, mon_e.rp,
                          mon_e.hit, mon_e.miss, mon_e.spd, mon_e.st));
        end
      end
      if (t2) begin
        check("pulse_end", bus.hit == 2'b00 && bus.miss == 2'b00 && int'(bus.state) == mon_post,
              $sformatf("got hit=%0d miss=%0d st=%0d want 0/0/%0d", bus.hit, bus.miss,
                        bus.state, mon_post));
      end
    end
  end

  initial begin
    logic [3:0] b;
    int mid, cen;
    bus.frame_tick = 1'b0; bus.btn = 4'b0; bus.serve = 1'b0; bus.pause = 1'b0;
    reset = 1'b1;
    model_reset();
    #12 check_reset_vals("reset_values");
    @(negedge clk);
    reset = 1'b0;

    // Both left buttons go down, then hold down to the floor, then up to the ceiling.
    repeat (5)   frame(4'b1100, 1'b0, 1'b0);
    repeat (100) frame(4'b1000, 1'b0, 1'b0);
    check("pad_floor", bus.l_pad_y == 10'd399, $sformatf("got %0d want 399", bus.l_pad_y));
    repeat (110) frame(4'b0100, 1'b0, 1'b0);
    check("pad_ceiling", bus.l_pad_y == 10'd72, $sformatf("got %0d want 72", bus.l_pad_y));

    for (int i = 0; i < 300; i++) begin
      if (m_lfsr[1:0] == 2'b11) break;
      step();
    end
    bus.serve = 1'b1;
    model_serve();
    step();
    bus.serve = 1'b0;
    repeat (DefServeFrames) frame(4'b0000, 1'b0, 1'b0);
    repeat (10) frame(4'b0000, 1'b1, 1'b0);
    frame(4'b0000, 1'b0, 1'b0);
    check("first_move", bus.ball_x == 10'd317 && bus.ball_y == 10'd237,
          $sformatf("got (%0d,%0d) want (317,237)", bus.ball_x, bus.ball_y));

    for (int i = 0; i < 7000; i++) begin
      if (i == 3500) begin
        #2 reset = 1'b1;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        model_reset();
        reset = 1'b0;
      end
      mid = m_by + BS / 2;
      b   = 4'b0000;
      cen = m_rp + PH / 2;
      if (mid > cen + 2) b[1] = 1'b1; else if (mid < cen - 2) b[0] = 1'b1;
      cen = m_lp + PH / 2;
      if (mid > cen + 2) b[3] = 1'b1; else if (mid < cen - 2) b[2] = 1'b1;
      if ($urandom_range(0, 99) < 15) b = 4'($urandom_range(0, 15));
      frame(b, $urandom_range(0, 99) < 5,
            $urandom_range(0, 9) == 0 || ((m_st == 0 || m_st == 3) && $urandom_range(0, 2) == 0));
    end

    check("queue_drained", q_exp.size() == 0, $sformatf("got %0d left want 0", q_exp.size()));
    $display("model saw %0d paddle hits and %0d misses", n_hits, n_miss);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
